// File: rtl/cgra_cfg_loader.sv
// cgra_cfg_loader: streams FH configuration frames from a valid/ready word
// source onto a CGRA tile's configuration port. Each frame gets a one-cycle
// one-hot strobe with SETUP_CYC cycles of data setup and HOLD_CYC cycles of
// hold. The fabric clear line stays high for the whole load, and done is
// sticky once all frames are written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no load since reset; waiting for start
// WAIT    | in_ready high; waiting for the next frame word
// SETUP   | word latched on cfg_data; counting down setup cycles
// STROBE  | single cycle with cfg_strb = 1 << idx
// HOLD    | strobe low, data held; counting down hold cycles
// DONE    | all frames written; done high until the next start
module cgra_cfg_loader #(
  parameter int FW        = 32,
  parameter int FH        = 2,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [FW-1:0] cfg_data,
  output logic [FH-1:0] cfg_strb,
  output logic          clr,
  output logic          busy,
  output logic          done
);

  localparam int IW   = (FH > 1) ? $clog2(FH) : 1;
  localparam int MAXP = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  // Down-counter load values: a phase of N cycles runs from N-1 to zero.
  localparam logic [PW-1:0] SETUP_LOAD = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] HOLD_LOAD  = PW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(FH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] cnt_q;
  logic [IW-1:0] idx_q;

  logic cnt_tc;
  logic idx_last;

  assign cnt_tc   = (cnt_q == '0);
  assign idx_last = (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured while not loading.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_valid) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_tc) state_d = S_STROBE;
      end
      S_STROBE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_tc) state_d = idx_last ? S_DONE : S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame data latch, frame index and phase down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_data <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) idx_q <= '0;
        end
        S_WAIT: begin
          if (in_valid) begin
            cfg_data <= in_data;
            cnt_q    <= SETUP_LOAD;
          end
        end
        S_SETUP: begin
          if (!cnt_tc) cnt_q <= cnt_q - PW'(1);
        end
        S_STROBE: begin
          cnt_q <= HOLD_LOAD;
        end
        S_HOLD: begin
          if (!cnt_tc) begin
            cnt_q <= cnt_q - PW'(1);
          end else if (!idx_last) begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state so none follow an input.
  assign in_ready = (state_q == S_WAIT);
  assign busy     = (state_q == S_WAIT) || (state_q == S_SETUP) ||
                    (state_q == S_STROBE) || (state_q == S_HOLD);
  assign clr      = busy;
  assign done     = (state_q == S_DONE);
  assign cfg_strb = (state_q == S_STROBE) ? (FH'(1) << idx_q) : '0;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Directed bench for cgra_cfg_loader: a default instance (FH=2, 1/1 phases)
// and a custom instance (FH=3, SETUP 3, HOLD 2) share clock and reset.
module tb_cgra_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_start, a_valid, a_ready, a_clr, a_busy, a_done;
  logic [31:0] a_in_data, a_cfg_data;
  logic [1:0]  a_strb;

  logic        b_start, b_valid, b_ready, b_clr, b_busy, b_done;
  logic [31:0] b_in_data, b_cfg_data;
  logic [2:0]  b_strb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cgra_cfg_loader #(.FW(32), .FH(2), .SETUP_CYC(1), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_data(a_in_data),
    .in_valid(a_valid), .in_ready(a_ready), .cfg_data(a_cfg_data),
    .cfg_strb(a_strb), .clr(a_clr), .busy(a_busy), .done(a_done)
  );

  cgra_cfg_loader #(.FW(32), .FH(3), .SETUP_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_data(b_in_data),
    .in_valid(b_valid), .in_ready(b_ready), .cfg_data(b_cfg_data),
    .cfg_strb(b_strb), .clr(b_clr), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".in_ready"}, {31'd0, a_ready}, 32'd0);
    chk({tag, ".cfg_data"}, a_cfg_data, 32'd0);
    chk({tag, ".cfg_strb"}, {30'd0, a_strb}, 32'd0);
    chk({tag, ".clr"}, {31'd0, a_clr}, 32'd0);
    chk({tag, ".busy"}, {31'd0, a_busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, a_done}, 32'd0);
  endtask

  // Full default load with in_valid held high; n counts cycles after start.
  // n=1 WAIT, 2 SETUP, 3 STROBE(01), 4 HOLD, 5 WAIT, 6 SETUP, 7 STROBE(10),
  // 8 HOLD, 9.. DONE. in_valid stays high in DONE and must not be accepted.
  task automatic default_load(input logic [31:0] d0, input logic [31:0] d1, input string tag);
    logic [31:0] e_data, e_strb;
    a_in_data = d0;
    a_valid   = 1'b1;
    a_start   = 1'b1;
    tick();
    a_start   = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      e_data = (n < 2) ? a_cfg_data : ((n < 6) ? d0 : d1);
      if (n == 1) begin
        chk({tag, ".start_ready"}, {31'd0, a_ready}, 32'd1);
        chk({tag, ".start_clr"}, {31'd0, a_clr}, 32'd1);
      end
      if (n >= 2) chk({tag, ".data"}, a_cfg_data, e_data);
      e_strb = (n == 3) ? 32'd1 : ((n == 7) ? 32'd2 : 32'd0);
      chk({tag, ".strb"}, {30'd0, a_strb}, e_strb);
      chk({tag, ".done"}, {31'd0, a_done}, (n >= 9) ? 32'd1 : 32'd0);
      chk({tag, ".clr"}, {31'd0, a_clr}, (n < 9) ? 32'd1 : 32'd0);
      if (n >= 9) chk({tag, ".done_ready"}, {31'd0, a_ready}, 32'd0);
      if (n >= 1) a_in_data = (n < 5) ? d0 : d1;
      if (n >= 9) a_in_data = 32'hFFFF_0000;
      tick();
    end
    a_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] e_strb, e_data;
    rst = 1'b1;
    a_start = 1'($urandom_range(0, 1));
    a_valid = 1'($urandom_range(0, 1));
    a_in_data = $urandom;
    b_start = 1'b0; b_valid = 1'b0; b_in_data = '0;
    tick();
    a_start = 1'($urandom_range(0, 1));
    a_valid = 1'($urandom_range(0, 1));
    a_in_data = $urandom;
    tick();
    chk_a_zero("reset");
    rst = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_in_data = '0;
    for (int i = 0; i < 5; i++) tick();
    chk_a_zero("idle");

    // Default load; start and in_valid together means the word waits a cycle.
    a_in_data = 32'hDEAD_BEEF;
    a_valid = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("startvalid.data", a_cfg_data, 32'd0);
    chk("startvalid.ready", {31'd0, a_ready}, 32'd1);
    // Finish this load, then run the checked default load from DONE.
    for (int i = 0; i < 8; i++) begin
      a_in_data = (i < 3) ? 32'hDEAD_BEEF : 32'h1234_5678;
      tick();
    end
    chk("preload.done", {31'd0, a_done}, 32'd1);
    default_load(32'hDEAD_BEEF, 32'h1234_5678, "load");

    // Second load: start pulse during SETUP ignored, 7-cycle source stall.
    a_in_data = 32'hAAAA_0001;
    a_valid = 1'b1;
    a_start = 1'b1;
    tick();                                                      // n=1 WAIT
    a_start = 1'b0;
    chk("stall.done_cleared", {31'd0, a_done}, 32'd0);
    tick();                                                      // n=2 SETUP
    chk("stall.setup_strb", {30'd0, a_strb}, 32'd0);
    a_start = 1'b1;
    a_valid = 1'b0;
    tick();                                                      // n=3 STROBE
    a_start = 1'b0;
    chk("ignored_start.strb", {30'd0, a_strb}, 32'd1);
    chk("ignored_start.data", a_cfg_data, 32'hAAAA_0001);
    a_in_data = 32'hBBBB_0002;
    tick();                                                      // n=4 HOLD
    chk("ignored_start.busy", {31'd0, a_busy}, 32'd1);
    for (int n = 5; n <= 11; n++) begin
      tick();                                                    // WAIT stall
      chk("stall.ready", {31'd0, a_ready}, 32'd1);
      chk("stall.strb", {30'd0, a_strb}, 32'd0);
      chk("stall.data", a_cfg_data, 32'hAAAA_0001);
    end
    a_valid = 1'b1;
    tick();                                                      // n=12 SETUP
    a_valid = 1'b0;
    chk("stall.data2", a_cfg_data, 32'hBBBB_0002);
    chk("stall.setup2_strb", {30'd0, a_strb}, 32'd0);
    tick();                                                      // n=13 STROBE
    chk("stall.strb2", {30'd0, a_strb}, 32'd2);
    tick();                                                      // n=14 HOLD
    chk("stall.hold_done", {31'd0, a_done}, 32'd0);
    tick();                                                      // n=15 DONE
    chk("stall.done", {31'd0, a_done}, 32'd1);
    chk("stall.done_clr", {31'd0, a_clr}, 32'd0);

    // Reset during the frame-0 strobe.
    a_in_data = 32'hCCCC_0003;
    a_valid = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("rststrobe.strb_pre", {30'd0, a_strb}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b0;
    chk_a_zero("rststrobe");
    default_load(32'h0BAD_F00D, 32'h600D_CAFE, "postrst");

    // Custom instance: n=1 WAIT, SETUP 2-4, STROBE 5, HOLD 6-7, WAIT 8,
    // SETUP 9-11, STROBE 12, HOLD 13-14, WAIT 15, SETUP 16-18, STROBE 19,
    // HOLD 20-21, DONE 22.
    b_in_data = 32'h1111_1111;
    b_valid = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      e_strb = (n == 5) ? 32'd1 : ((n == 12) ? 32'd2 : ((n == 19) ? 32'd4 : 32'd0));
      e_data = (n < 2) ? 32'd0 : ((n < 9) ? 32'h1111_1111 :
               ((n < 16) ? 32'h2222_2222 : 32'h3333_3333));
      chk("custom.strb", {29'd0, b_strb}, e_strb);
      chk("custom.data", b_cfg_data, e_data);
      chk("custom.done", {31'd0, b_done}, (n >= 22) ? 32'd1 : 32'd0);
      chk("custom.busy", {31'd0, b_busy}, (n < 22) ? 32'd1 : 32'd0);
      b_in_data = (n < 8) ? 32'h1111_1111 : ((n < 15) ? 32'h2222_2222 : 32'h3333_3333);
      tick();
    end
    b_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
